adder_share_ctrl: RTL and testbench
===================================

// Module: adder_share_ctrl
// PURPOSE
//  Shares one full_adder-chain 32-bit adder (adder_32bit) between N_REQ requesters.
//  Round-robin grant, valid/ready handshake per requester, registered result with ID tag.
//  Sits between ALU/address-gen clients and the single adder instance; one op in flight.
// PARAMETERS
//  N_REQ    4    number of requesters (2..8)
//  ID_W     2    width of rsp_id_o = $clog2(N_REQ)
// PORTS
//  clk_i        in   1          clock, all logic rising-edge
//  rst_i        in   1          synchronous, active-high reset
//  req_valid_i  in   N_REQ      per-requester operation request
//  req_a_i      in   N_REQ*32   operand A, requester k at [32k+31:32k]
//  req_b_i      in   N_REQ*32   operand B, same packing
//  req_cin_i    in   N_REQ      carry-in (Pin of adder)
//  req_ready_o  out  N_REQ      one-hot accept; handshake = valid & ready
//  rsp_valid_o  out  1          result valid
//  rsp_ready_i  in   1          consumer accepts result
//  rsp_id_o     out  ID_W       index of requester owning result
//  rsp_sum_o    out  32         S of adder
//  rsp_cout_o   out  1          Pout of adder
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, rsp_valid_o=0, rsp_id_o=0, rsp_sum_o=0, rsp_cout_o=0,
//   operand regs=0; req_ready_o=0 in the reset cycle (forced low while rst_i=1).
//  FSM IDLE -> CALC -> RESP -> IDLE.
//  IDLE: if |req_valid_i: grant g = first valid at or after rr_ptr (wrapping mod N_REQ);
//   req_ready_o = onehot(g) combinationally this cycle only; latch a,b,cin,id=g;
//   rr_ptr <= (g+1) mod N_REQ; -> CALC. No valid: req_ready_o=0, stay.
//  CALC: operand regs drive adder; register S/Pout into rsp_*; rsp_valid_o<=1; -> RESP.
//  RESP: hold rsp_* stable while rsp_valid_o & !rsp_ready_i. On rsp_ready_i:
//   rsp_valid_o<=0, -> IDLE. req_ready_o=0 in CALC and RESP.
//  Latency: accept at cycle t -> rsp_valid_o high at t+2. Min issue interval 3 cycles.
//  Arithmetic: 32-bit modulo sum, cout = bit 32 of a+b+cin; no overflow flag.
//  Requester dropping valid while not granted: allowed, no state kept.
//  rsp_ready_i high outside RESP: ignored.
//  rst_i mid-operation (CALC/RESP): op discarded, full reset values next cycle.
//  Fairness: requester continuously valid is granted within N_REQ grants.
// CONFIGURATION
//  ADDER_SHARE_SUB_EN defined: extra input req_sub_i[N_REQ]; when granted with
//   req_sub_i=1, latched B = ~req_b_i and cin = 1 (req_cin_i ignored) -> a-b,
//   cout = 1 means no borrow. Undefined: port absent, add only.
// STRUCTURE
//  Package adder_share_pkg: state enum {IDLE, CALC, RESP} (2-bit), DATA_W=32,
//   ID_W function/constant.
//  Sub-module rr_arbiter (N_REQ): req vector + ptr -> onehot grant + index.
//  Instantiates one adder_32bit; no other arithmetic on the datapath.
// TESTING
//  1 Single req0 a=5,b=7,cin=0 -> ready0 same cycle; 2 cycles later sum=12,cout=0,id=0.
//  2 a=FFFFFFFF,b=1,cin=0 -> sum=0,cout=1; a=FFFFFFFF,b=0,cin=1 -> sum=0,cout=1.
//  3 All 4 valid continuously from reset -> grant order 0,1,2,3,0; ids match.
//  4 rsp_ready_i low 5 cycles in RESP -> rsp_* stable, no new req_ready_o pulse.
//  5 rst_i asserted in CALC -> next cycle rsp_valid_o=0, rr_ptr=0, state IDLE.
//  6 SUB_EN: a=10,b=3,sub=1 -> sum=7,cout=1; a=3,b=10 -> sum=FFFFFFF9,cout=0.

Source files
------------

// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared types and constants for the shared-adder controller.
//   state_e : controller FSM states (IDLE, CALC, RESP), 2-bit encoding
//   DATA_W  : operand/result width
//   id_w()  : requester-index width for a given requester count
package adder_share_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic int id_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/adder_share_ctrl_if.sv
// adder_share_ctrl_if: request/response bus between the requesters and the
// shared-adder controller.
//   req_valid_i/req_ready_o : per-requester handshake (ready is one-hot)
//   req_a_i/req_b_i/req_cin_i : per-requester operands
//   req_sub_i : per-requester subtract select (only with ADDER_SHARE_SUB_EN)
//   rsp_valid_o/rsp_ready_i : result handshake
//   rsp_id_o/rsp_sum_o/rsp_cout_o : result payload
// master = requester/consumer side, slave = controller side.
interface adder_share_ctrl_if
    #(parameter int N_REQ = 4,
      parameter int ID_W  = adder_share_pkg::id_w(N_REQ));

    import adder_share_pkg::*;

    logic [N_REQ-1:0]             req_valid_i;
    logic [N_REQ-1:0][DATA_W-1:0] req_a_i;
    logic [N_REQ-1:0][DATA_W-1:0] req_b_i;
    logic [N_REQ-1:0]             req_cin_i;
`ifdef ADDER_SHARE_SUB_EN
    logic [N_REQ-1:0]             req_sub_i;
`endif
    logic [N_REQ-1:0]             req_ready_o;
    logic                         rsp_valid_o;
    logic                         rsp_ready_i;
    logic [ID_W-1:0]              rsp_id_o;
    logic [DATA_W-1:0]            rsp_sum_o;
    logic                         rsp_cout_o;

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_cin_i,
`ifdef ADDER_SHARE_SUB_EN
        output req_sub_i,
`endif
        input  req_ready_o,
        input  rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_cout_o,
        output rsp_ready_i
    );

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_cin_i,
`ifdef ADDER_SHARE_SUB_EN
        input  req_sub_i,
`endif
        output req_ready_o,
        output rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_cout_o,
        input  rsp_ready_i
    );

endinterface

// File: rtl/adder_32bit.sv
// adder_32bit: 32-bit ripple-carry adder built from a chain of full-adder cells.
//   A, B : operands
//   Pin  : carry in
//   S    : 32-bit sum
//   Pout : carry out of bit 31
module adder_32bit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Pin,
    output logic [31:0] S,
    output logic        Pout
);

    logic [32:0] c;

    assign c[0] = Pin;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Pout = c[32];

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req : request vector
//   ptr : highest-priority index this round
//   gnt : one-hot grant (first request at or after ptr, wrapping)
//   idx : index of the granted requester
//   any : at least one request present
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    int k;

    // Scan offsets from farthest to nearest so the nearest request to ptr
    // is the last one written and therefore wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N_REQ;
            if (req[k]) begin
                idx = ID_W'(k);
                any = 1'b1;
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: shares one adder_32bit between N_REQ requesters.
// Round-robin grant, one operation in flight, registered tagged result.
//   clk_i : clock (rising edge)
//   rst_i : synchronous active-high reset
//   bus   : adder_share_ctrl_if slave (request handshakes, operands, result)
// Optional: define ADDER_SHARE_SUB_EN to add per-requester req_sub_i, which
// turns the granted operation into a - b (b inverted, carry-in forced to 1).
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    adder_share_ctrl_if.slave bus
);

    localparam int ID_W = id_w(N_REQ);

    state_e              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [N_REQ-1:0]    gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_any;

    logic [DATA_W-1:0]   op_a, op_b;
    logic                op_cin;
    logic [ID_W-1:0]     op_id;

    logic [DATA_W-1:0]   sel_b;
    logic                sel_cin;
    logic [DATA_W-1:0]   add_s;
    logic                add_cout;

    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_sum_q;
    logic                rsp_cout_q;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req (bus.req_valid_i),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // Operand B / carry-in as they will be latched for the granted requester.
    always_comb begin
        sel_b   = bus.req_b_i[gnt_idx];
        sel_cin = bus.req_cin_i[gnt_idx];
`ifdef ADDER_SHARE_SUB_EN
        if (bus.req_sub_i[gnt_idx]) begin
            sel_b   = ~bus.req_b_i[gnt_idx];
            sel_cin = 1'b1;
        end
`endif
    end

    // Ready is the only combinational output: the accept must land in the
    // same cycle the arbiter picks, and it is held low through reset.
    assign bus.req_ready_o = (state == IDLE && !rst_i) ? gnt : '0;

    adder_32bit u_add (
        .A    (op_a),
        .B    (op_b),
        .Pin  (op_cin),
        .S    (add_s),
        .Pout (add_cout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_cin      <= 1'b0;
            op_id       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        op_a   <= bus.req_a_i[gnt_idx];
                        op_b   <= sel_b;
                        op_cin <= sel_cin;
                        op_id  <= gnt_idx;
                        rr_ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum_q   <= add_s;
                    rsp_cout_q  <= add_cout;
                    rsp_id_q    <= op_id;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_id_o    = rsp_id_q;
    assign bus.rsp_sum_o   = rsp_sum_q;
    assign bus.rsp_cout_o  = rsp_cout_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl: directed stimulus for adder_share_ctrl with a
// transaction-level model (pending-result queue + round-robin pointer)
// checked against the DUT on every falling edge, plus literal expectations.
module tb_adder_share_ctrl;
    import adder_share_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_share_ctrl_if #(.N_REQ(N)) bus();
    logic [N-1:0] tb_sub = '0;
`ifdef ADDER_SHARE_SUB_EN
    assign bus.req_sub_i = tb_sub;
`endif

    adder_share_ctrl #(.N_REQ(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        cout;
        int          vis;
    } exp_t;

    exp_t        q[$];
    int          m_ptr     = 0;
    int          cyc       = 0;
    int          last_id   = 0;
    logic [31:0] last_sum  = '0;
    logic        last_cout = 1'b0;
    int          dlog[$];

    int          g;
    logic [N-1:0] er;
    logic        ev;
    logic [31:0] beff;
    logic [32:0] full;
    exp_t        e;

    always @(negedge clk) begin
        // Expected grant: controller is free only when nothing is pending.
        g  = -1;
        er = '0;
        if (!rst && q.size() == 0)
            for (int i = 0; i < N; i++)
                if (g < 0 && bus.req_valid_i[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        if (g >= 0) er[g] = 1'b1;
        ev = (q.size() > 0) && (cyc >= q[0].vis);

        chk("req_ready", 64'(bus.req_ready_o), 64'(er));
        chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(ev));
        if (ev) begin
            chk("rsp_id",   64'(bus.rsp_id_o),   64'(q[0].id));
            chk("rsp_sum",  64'(bus.rsp_sum_o),  64'(q[0].sum));
            chk("rsp_cout", 64'(bus.rsp_cout_o), 64'(q[0].cout));
        end else begin
            chk("hold_id",   64'(bus.rsp_id_o),   64'(last_id));
            chk("hold_sum",  64'(bus.rsp_sum_o),  64'(last_sum));
            chk("hold_cout", 64'(bus.rsp_cout_o), 64'(last_cout));
        end

        for (int i = 0; i < N; i++)
            if (bus.req_ready_o[i]) dlog.push_back(i);

        if (rst) begin
            q.delete();
            m_ptr = 0; last_id = 0; last_sum = '0; last_cout = 1'b0;
        end else begin
            if (ev && bus.rsp_ready_i) begin
                last_id = q[0].id; last_sum = q[0].sum; last_cout = q[0].cout;
                void'(q.pop_front());
            end
            if (g >= 0) begin
                beff = tb_sub[g] ? ~bus.req_b_i[g] : bus.req_b_i[g];
                full = {1'b0, bus.req_a_i[g]} + {1'b0, beff}
                     + 33'(tb_sub[g] ? 1'b1 : bus.req_cin_i[g]);
                e.id = g; e.sum = full[31:0]; e.cout = full[32]; e.vis = cyc + 2;
                q.push_back(e);
                m_ptr = (g + 1) % N;
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_grant(input int k);
        logic got;
        got = 1'b0;
        for (int t = 0; t < 30 && !got; t++) begin
            @(negedge clk);
            if (bus.req_ready_o[k]) got = 1'b1;
        end
        chk("grant_wait", 64'(got), 64'(1));
    endtask

    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
        @(posedge clk); #1;
        bus.req_a_i[k]   = a;
        bus.req_b_i[k]   = b;
        bus.req_cin_i[k] = cin;
        tb_sub[k]        = sub;
        bus.req_valid_i[k] = 1'b1;
        wait_grant(k);
        @(posedge clk); #1;
        bus.req_valid_i[k] = 1'b0;
    endtask

    // Counts falling edges until a result shows; 2 means accept -> t+2.
    task automatic wait_rsp(output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid_o) seen = 1'b1;
        end
        chk("rsp_wait", 64'(seen), 64'(1));
    endtask

    task automatic op_check(input string name, input int k, input logic [31:0] a,
                            input logic [31:0] b, input logic cin, input logic sub,
                            input logic [31:0] xsum, input logic xcout);
        int n;
        issue(k, a, b, cin, sub);
        wait_rsp(n);
        chk({name, "_lat"},  64'(n), 64'(2));
        chk({name, "_sum"},  64'(bus.rsp_sum_o), 64'(xsum));
        chk({name, "_cout"}, 64'(bus.rsp_cout_o), 64'(xcout));
        chk({name, "_id"},   64'(bus.rsp_id_o), 64'(k));
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n_tmp;

    initial begin
        #150000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid_i = '0;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        bus.req_cin_i   = '0;
        bus.rsp_ready_i = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("reset_sum",   64'(bus.rsp_sum_o),   64'(0));
        chk("reset_ready", 64'(bus.req_ready_o), 64'(0));

        // Basic add and carry boundaries.
        op_check("t1",   0, 32'd5,        32'd7,        1'b0, 1'b0, 32'd12, 1'b0);
        op_check("t2a",  1, 32'hFFFF_FFFF, 32'd1,       1'b0, 1'b0, 32'd0,  1'b1);
        op_check("t2b",  2, 32'hFFFF_FFFF, 32'd0,       1'b1, 1'b0, 32'd0,  1'b1);
        op_check("t2c",  3, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'd1, 1'b1);

        // Consumer stall: result held, no new accept while req0 waits.
        @(posedge clk); #1 bus.rsp_ready_i = 1'b0;
        issue(3, 32'h1234_0000, 32'h0000_5678, 1'b1, 1'b0);
        bus.req_a_i[0] = 32'd100; bus.req_b_i[0] = 32'd23; bus.req_cin_i[0] = 1'b0;
        tb_sub[0] = 1'b0;
        bus.req_valid_i[0] = 1'b1;
        wait_rsp(n_tmp);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(bus.rsp_valid_o), 64'(1));
            chk("t4_hold_sum",   64'(bus.rsp_sum_o),   64'h1234_5679);
            chk("t4_no_ready",   64'(bus.req_ready_o), 64'(0));
        end
        @(posedge clk); #1 bus.rsp_ready_i = 1'b1;
        wait_grant(0);
        @(posedge clk); #1 bus.req_valid_i[0] = 1'b0;
        repeat (4) @(posedge clk);

        // All requesters valid straight out of reset.
        #1 rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            bus.req_a_i[k] = 32'(k * 100); bus.req_b_i[k] = 32'(k);
            bus.req_cin_i[k] = 1'b0; tb_sub[k] = 1'b0;
        end
        bus.req_valid_i = '1;
        repeat (2) @(posedge clk);
        dlog.delete();
        #1 rst = 1'b0;
        for (int t = 0; t < 60 && dlog.size() < 5; t++) @(negedge clk);
        @(posedge clk); #1 bus.req_valid_i = '0;
        chk("t3_ngrants", 64'(dlog.size()), 64'(5));
        for (int i = 0; i < 5; i++)
            if (i < dlog.size()) chk("t3_order", 64'(dlog[i]), 64'(exp_order[i]));
        repeat (4) @(posedge clk);

        // Reset during CALC: op discarded, pointer back to 0.
        issue(2, 32'd1, 32'd2, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid_i[0] = 1'b1;
        bus.req_valid_i[3] = 1'b1;
        @(negedge clk);
        chk("t5_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("t5_sum",   64'(bus.rsp_sum_o),   64'(0));
        chk("t5_grant", 64'(bus.req_ready_o), 64'(4'b0001));
        @(posedge clk); #1 bus.req_valid_i = '0;
        repeat (4) @(posedge clk);

`ifdef ADDER_SHARE_SUB_EN
        op_check("t6a", 1, 32'd10, 32'd3,  1'b0, 1'b1, 32'd7,          1'b1);
        op_check("t6b", 1, 32'd3,  32'd10, 1'b0, 1'b1, 32'hFFFF_FFF9,  1'b0);
`endif
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
